// File: rtl/core_pkg.sv
// Shared types and constants for the execute-stage hazard logic.
// Forward select encodings and the shadow pipeline slot layout.
package core_pkg;

  localparam int REG_AW = 4;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic [REG_AW-1:0] dest;
    logic              mem_r;
  } slot_t;

endpackage

// File: rtl/hazard_slot_match.sv
// Compares one shadow slot against the ID source operands.
// src2 only counts when the ID instruction really reads it.
module hazard_slot_match
  import core_pkg::*;
(
  input  slot_t             slot,
  input  logic [REG_AW-1:0] src1,
  input  logic [REG_AW-1:0] src2,
  input  logic              two_src,
  output logic              m1,
  output logic              m2,
  output logic              hit,
  output logic              ld_hit
);

  logic prod;

  // Slot is a live producer; match each operand, then flag loads.
  always_comb begin
    prod   = slot.valid & slot.wb_en;
    m1     = prod & (slot.dest == src1);
    m2     = prod & two_src & (slot.dest == src2);
    hit    = m1 | m2;
    ld_hit = hit & slot.mem_r;
  end

endmodule

// File: rtl/exec_hazard_ctrl.sv
// Hazard, forwarding and flush control for the five-stage core.
// Tracks EXE/MEM/WB producer tags to drive stalls and forward selects.
module exec_hazard_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fwd_en,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic              id_wb_en,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_mem_r_en,
  input  logic              branch_taken,
  output logic              stall,
  output logic              flush,
  output logic              id_ex_bubble,
  output logic [1:0]        src1_sel,
  output logic [1:0]        src2_sel,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  slot_t exe_q, exe_d;
  slot_t mem_q, mem_d;
  slot_t wb_q, wb_d;
  logic [1:0] src1_sel_q, src1_sel_d;
  logic [1:0] src2_sel_q, src2_sel_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic exe_m1, exe_m2, exe_hit, exe_ld;
  logic mem_m1, mem_m2, mem_hit, unused_mem_ld;
  logic unused_wb_m1, unused_wb_m2;
  logic unused_wb_hit, unused_wb_ld;
  logic hazard, advance;

  hazard_slot_match u_exe (
    .slot    (exe_q),
    .src1    (id_src1),
    .src2    (id_src2),
    .two_src (id_two_src),
    .m1      (exe_m1),
    .m2      (exe_m2),
    .hit     (exe_hit),
    .ld_hit  (exe_ld)
  );

  hazard_slot_match u_mem (
    .slot    (mem_q),
    .src1    (id_src1),
    .src2    (id_src2),
    .two_src (id_two_src),
    .m1      (mem_m1),
    .m2      (mem_m2),
    .hit     (mem_hit),
    .ld_hit  (unused_mem_ld)
  );

  // WB never stalls: the register file writes before it is read.
  hazard_slot_match u_wb (
    .slot    (wb_q),
    .src1    (id_src1),
    .src2    (id_src2),
    .two_src (id_two_src),
    .m1      (unused_wb_m1),
    .m2      (unused_wb_m2),
    .hit     (unused_wb_hit),
    .ld_hit  (unused_wb_ld)
  );

  // Hazard detect; a taken branch discards ID and overrides the stall.
  always_comb begin
    hazard       = fwd_en ? exe_ld : (exe_hit | mem_hit);
    stall        = id_valid & hazard & ~branch_taken;
    flush        = branch_taken;
    id_ex_bubble = stall | branch_taken;
    advance      = id_valid & ~id_ex_bubble;
  end

  // Next shadow slots, forward selects and saturating counters.
  always_comb begin
    exe_d = '0;
    if (advance) begin
      exe_d.valid = 1'b1;
      exe_d.wb_en = id_wb_en;
      exe_d.dest  = id_dest;
      exe_d.mem_r = id_mem_r_en;
    end
    mem_d = exe_q;
    wb_d  = mem_q;

    src1_sel_d = FWD_RF;
    src2_sel_d = FWD_RF;
    if (advance & fwd_en) begin
      if (exe_m1 & ~exe_q.mem_r) begin
        src1_sel_d = FWD_MEM;
      end else if (mem_m1) begin
        src1_sel_d = FWD_WB;
      end
      if (exe_m2 & ~exe_q.mem_r) begin
        src2_sel_d = FWD_MEM;
      end else if (mem_m2) begin
        src2_sel_d = FWD_WB;
      end
    end

    stall_cnt_d = stall_cnt_q;
    if (stall & ~&stall_cnt_q) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    flush_cnt_d = flush_cnt_q;
    if (flush & ~&flush_cnt_q) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State update with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exe_q       <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      src1_sel_q  <= FWD_RF;
      src2_sel_q  <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      exe_q       <= exe_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      src1_sel_q  <= src1_sel_d;
      src2_sel_q  <= src2_sel_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign src1_sel    = src1_sel_q;
  assign src2_sel    = src2_sel_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: doc/exec_hazard_ctrl.md
Name: exec_hazard_ctrl

Overview:
Pipeline hazard and forwarding controller for the ARM five-stage core.
- Keeps a shadow pipeline of in-flight destination/source tags across the EXE, MEM and WB stages.
- Drives the EXEC stage forwarding selects (src1_sel, src2_sel).
- Detects load-use and no-forwarding RAW hazards and issues stall/bubble.
- Applies branch flush and keeps saturating stall/flush event counters.
- Sits between the ID stage outputs and the ID/EX register / EXEC stage.

Parameters:
- REG_AW, 4, register index width.
- CNT_W, 16, width of the stall/flush event counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- fwd_en  in  1  1 = forwarding enabled; 0 = resolve every RAW hazard by stalling
- id_valid  in  1  ID stage holds a real instruction
- id_src1  in  REG_AW  Rn index of ID instruction
- id_src2  in  REG_AW  Rm/Rd-store index of ID instruction
- id_two_src  in  1  id_src2 is a real operand (register shift operand or store)
- id_wb_en  in  1  ID instruction writes a register
- id_dest  in  REG_AW  ID instruction destination
- id_mem_r_en  in  1  ID instruction is a load
- branch_taken  in  1  branch resolved taken by the instruction in EXE
- stall  out  1  freeze PC and IF/ID (combinational)
- flush  out  1  clear IF/ID (combinational, equals branch_taken)
- id_ex_bubble  out  1  load NOP into ID/EX this edge (combinational)
- src1_sel  out  2  EXEC val_rn select: 00 reg file, 01 mem_alu_res, 10 wb_value (registered)
- src2_sel  out  2  EXEC val_rm select, same encoding (registered)
- stall_count  out  CNT_W  saturating count of stall cycles
- flush_count  out  CNT_W  saturating count of flushes

Behaviour:
- Shadow slots EXE, MEM and WB. Each slot holds {valid, wb_en, dest, mem_r}.
- Every edge: WB<=MEM, MEM<=EXE.
- EXE<=ID tags when id_valid & !id_ex_bubble; otherwise EXE<=invalid.
- Match rule: match(slot, r) = slot.valid & slot.wb_en & slot.dest==r. It applies to id_src1 always, and to id_src2 only when id_two_src.
- Hazard with fwd_en=1: any match on the EXE slot with EXE.mem_r=1 (load-use). Exactly 1 stall cycle.
- Hazard with fwd_en=0: any match on the EXE or MEM slot. Up to 2 stall cycles. The WB slot never stalls because the register file is write-first.
- stall = id_valid & hazard & !branch_taken.
- flush = branch_taken.
- id_ex_bubble = stall | branch_taken.
- Forward selects are registered on the edge where ID moves into EXE (id_valid & !id_ex_bubble), so they align with the instruction now in EXE:
  - sel <= 01 if fwd_en & match(EXE,src) & !EXE.mem_r;
  - else 10 if fwd_en & match(MEM,src);
  - else 00.
  - The EXE slot has priority over MEM (youngest producer wins).
  - src2_sel <= 00 when !id_two_src.
- On a bubble edge both sels <= 00.
- Priority of simultaneous events: branch_taken > stall.
  - A taken branch during a hazard cancels the stall.
  - The ID instruction is discarded, not counted as a stall.
- Counters:
  - stall_count increments on each cycle with stall=1.
  - flush_count increments on each cycle with flush=1.
  - Both saturate at all-ones and never wrap.
- Register r15 (PC) and dest matches follow the same rules; no special case.
- Reset (rst_n=0 at an edge): all slots invalid, sels 00, counters 0.
  - Combinational outputs follow, so stall=0 the cycle after reset.
  - Reset mid-stall discards the pending hazard.
- No latency beyond the above. Stall/flush/bubble are zero-cycle from inputs; sels have a 1-edge latency.

Decomposition:
- Shared package core_pkg:
  - forwarding select constants FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - shadow slot struct type;
  - REG_AW.
- One sub-module, hazard_slot_match: combinational compare of a slot against src1/src2 with the two_src qualifier. It is instantiated once per slot (EXE, MEM, WB).

Test Plan:
- fwd_en=1, ADD r1 then SUB r2,r1,r3 back-to-back: no stall; src1_sel=01 in SUB's EXE cycle. A third dependent instruction two behind gets src1_sel=10.
- fwd_en=1, LDR r4 then ADD r5,r4,r6: stall=1 and id_ex_bubble=1 for exactly 1 cycle. ADD then enters EXE with src1_sel=10. stall_count=1.
- fwd_en=0, ADD r1 then ORR r2,r1: stall for 2 cycles. ORR executes with src1_sel=00. stall_count=2.
- Hazard and branch_taken in the same cycle: stall=0, flush=1, bubble=1. The EXE slot is invalid next cycle, so no forward from it. flush_count=1, stall_count unchanged.
- id_two_src=0, id_src2 equal to the EXE dest: no stall, src2_sel=00. Repeating with id_two_src=1 gives src2_sel=01.
- Force stall continuously for 2^CNT_W+5 cycles: stall_count holds 0xFFFF. Assert rst_n=0 for one edge mid-stall: counters 0, sels 00, stall=0.
